// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - MMIO word offsets inside the 32-byte window
//   - TX_STATUS bit positions
//   - address-decode select type
//   - byte-lane merge helper
package dmem_pkg;

  localparam logic [2:0] OFF_TOHOST = 3'd0;
  localparam logic [2:0] OFF_MTLO   = 3'd1;
  localparam logic [2:0] OFF_MTHI   = 3'd2;
  localparam logic [2:0] OFF_TXD    = 3'd3;
  localparam logic [2:0] OFF_TXS    = 3'd4;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 4;

  typedef enum logic [1:0] {SEL_RAM, SEL_MMIO, SEL_MISS} sel_t;

  // Replace only the lanes whose write enable is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [3:0]  we);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/u_txfifo.sv
// Byte FIFO used as the TX queue.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   enqueue request and byte (accepted when not full, or full with pop)
//   pop           dequeue request (ignored when empty)
//   rdata         head byte, 0 when empty
//   full, empty   occupancy flags
//   count         number of stored bytes, 0..DEPTH
module u_txfifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 wdata,
  input  logic                       pop,
  output logic [7:0]                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign count = cnt_q;
  assign rdata = empty ? 8'h00 : mem[rptr_q];

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/u_dmem.sv
// Data-SRAM port responder: word RAM with byte-lane writes and registered reads,
// plus an MMIO window (tohost/done, 64-bit mtime, byte TX FIFO).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   dat_a/dat_we/dat_wd/dat_re   core data port (byte address, lane writes, lane reads)
//   dat_rd                       registered read data, held while no read
//   tx_vld/tx_dat/tx_rdy         TX FIFO head, valid/ready
//   done/tohost                  simulation pass/fail reporting
//   bus_err                      sticky flag for accesses outside RAM and MMIO
module u_dmem
  import dmem_pkg::*;
#(
  parameter int unsigned AW        = 12,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int unsigned TXD       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dat_a,
  input  logic [3:0]  dat_we,
  input  logic [31:0] dat_wd,
  input  logic [3:0]  dat_re,
  output logic [31:0] dat_rd,
  output logic        tx_vld,
  output logic [7:0]  tx_dat,
  input  logic        tx_rdy,
  output logic        done,
  output logic [31:0] tohost,
  output logic        bus_err
);

  localparam int unsigned CW = $clog2(TXD) + 1;

  logic [31:0]   ram [2**AW];
  logic [AW-1:0] widx;
  logic [2:0]    off;
  sel_t          sel;
  logic          wr_req, rd_req;

  logic [31:0] rd_q, tohost_q, mthi_q, mmio_rdata, status, tohost_merged;
  logic [63:0] mtime_q;
  logic        done_q, bus_err_q, ovf_q;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    cnt3;

  logic unused_addr;
  assign unused_addr = ^dat_a[1:0];

  assign widx   = dat_a[AW+1:2];
  assign off    = dat_a[4:2];
  assign wr_req = (dat_we != 4'h0);
  assign rd_req = (dat_re != 4'h0);

  always_comb begin
    if (dat_a[31:AW+2] == '0)                  sel = SEL_RAM;
    else if (dat_a[31:5] == MMIO_BASE[31:5])   sel = SEL_MMIO;
    else                                       sel = SEL_MISS;
  end

  assign tohost_merged = merge_lanes(tohost_q, dat_wd, dat_we);

  assign tx_push = !rst && wr_req && (sel == SEL_MMIO) && (off == OFF_TXD) && dat_we[0];
  assign tx_pop  = tx_vld && tx_rdy;
  assign cnt3    = 3'(tx_cnt);

  always_comb begin
    status               = '0;
    status[ST_FULL]      = tx_full;
    status[ST_EMPTY]     = tx_empty;
    status[ST_OVF]       = ovf_q;
    status[ST_CNT_LSB+:3] = cnt3;
  end

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_TOHOST: mmio_rdata = tohost_q;
      OFF_MTLO:   mmio_rdata = mtime_q[31:0];
      OFF_MTHI:   mmio_rdata = mthi_q;
      OFF_TXS:    mmio_rdata = status;
      default:    mmio_rdata = '0;
    endcase
  end

  // RAM storage is never reset; writes in the reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_req && (sel == SEL_RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (dat_we[i]) ram[widx][8*i +: 8] <= dat_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= '0;
      tohost_q  <= '0;
      mthi_q    <= '0;
      mtime_q   <= '0;
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      // Nonblocking RAM read here gives read-before-write on same-address collisions.
      if (rd_req) begin
        case (sel)
          SEL_RAM: rd_q <= ram[widx];
          SEL_MMIO: begin
            rd_q <= mmio_rdata;
            // Snapshot the high half so a LO-then-HI read pair is coherent.
            if (off == OFF_MTLO) mthi_q <= mtime_q[63:32];
          end
          default: begin
            rd_q      <= '0;
            bus_err_q <= 1'b1;
          end
        endcase
      end
      if (wr_req) begin
        case (sel)
          SEL_MMIO: begin
            if (off == OFF_TOHOST) begin
              tohost_q <= tohost_merged;
              if (tohost_merged != '0) done_q <= 1'b1;
            end
            if (off == OFF_TXS && dat_we[0] && dat_wd[ST_OVF]) ovf_q <= 1'b0;
          end
          SEL_MISS: bus_err_q <= 1'b1;
          default: ;
        endcase
      end
      if (tx_push && tx_full && !tx_pop) ovf_q <= 1'b1;
    end
  end

  u_txfifo #(
    .DEPTH (TXD)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (dat_wd[7:0]),
    .pop   (tx_pop),
    .rdata (tx_dat),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  assign tx_vld  = !tx_empty;
  assign dat_rd  = rd_q;
  assign tohost  = tohost_q;
  assign done    = done_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_u_dmem.sv
module tb_u_dmem;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dat_a, dat_wd, dat_rd, tohost;
  logic [3:0]  dat_we, dat_re;
  logic        tx_vld, tx_rdy, done, bus_err;
  logic [7:0]  tx_dat;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic        rd_issued = 1'b0;

  always #5 clk = ~clk;

  u_dmem dut (
    .clk     (clk),
    .rst     (rst),
    .dat_a   (dat_a),
    .dat_we  (dat_we),
    .dat_wd  (dat_wd),
    .dat_re  (dat_re),
    .dat_rd  (dat_rd),
    .tx_vld  (tx_vld),
    .tx_dat  (tx_dat),
    .tx_rdy  (tx_rdy),
    .done    (done),
    .tohost  (tohost),
    .bus_err (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    dat_a  = a;
    dat_we = we;
    dat_wd = wd;
    cyc();
    dat_we = 4'h0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.val  = exp;
    rd_exp_q.push_back(e);
    dat_a  = a;
    dat_re = 4'hF;
    cyc();
    dat_re = 4'h0;
  endtask

  // Read data is presented one edge after the request was sampled.
  always @(posedge clk) rd_issued <= !rst && (dat_re != 4'h0);

  // Scoreboard monitor: reads and TX handshakes are checked as they appear.
  always @(negedge clk) begin
    if (rd_issued) begin
      if (rd_exp_q.size() == 0) begin
        check("rd_unexpected", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = rd_exp_q.pop_front();
        check(e.name, dat_rd, e.val);
      end
    end
    if (tx_vld && tx_rdy) begin
      if (tx_exp_q.size() == 0) begin
        check("tx_unexpected", {24'h0, tx_dat}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] b;
        b = tx_exp_q.pop_front();
        check("tx_dat", {24'h0, tx_dat}, {24'h0, b});
      end
    end
  end

  initial begin
    rst    = 1'b1;
    dat_a  = '0;
    dat_we = '0;
    dat_wd = '0;
    dat_re = '0;
    tx_rdy = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;

    check("rst_dat_rd", dat_rd, 32'h0);
    check("rst_tx_vld", {31'h0, tx_vld}, 32'h0);
    check("rst_tx_dat", {24'h0, tx_dat}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_tohost", tohost, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    bus_read("rst_mtime_lo", MB + 32'h4, 32'h0);

    // RAM byte lanes and hold.
    bus_write(32'h40, 4'hF, 32'hAABB_CCDD);
    bus_write(32'h40, 4'b0010, 32'h0000_1100);
    bus_read("ram_lanes", 32'h40, 32'hAABB_11DD);
    cyc();
    check("ram_hold1", dat_rd, 32'hAABB_11DD);
    cyc();
    check("ram_hold2", dat_rd, 32'hAABB_11DD);

    // Read-before-write on the same word.
    bus_write(32'h80, 4'hF, 32'h1234_5678);
    dat_we = 4'hF;
    dat_wd = 32'hFFFF_FFFF;
    bus_read("rbw_old", 32'h80, 32'h1234_5678);
    dat_we = 4'h0;
    bus_read("rbw_new", 32'h80, 32'hFFFF_FFFF);

    // mtime LO/HI coherency across a 32-bit carry.
    @(negedge clk);
    force dut.mtime_q = 64'h0000_0000_FFFF_FFFE;
    bus_read("mtime_lo", MB + 32'h4, 32'hFFFF_FFFE);
    release dut.mtime_q;
    cyc();
    bus_read("mtime_hi_shadow", MB + 32'h8, 32'h0);

    // TX FIFO overflow then drain.
    for (int b = 8'h41; b <= 8'h45; b++) begin
      bus_write(MB + 32'hC, 4'h1, 32'(b));
      if (b != 8'h45) tx_exp_q.push_back(8'(b));
    end
    bus_read("txs_full_ovf", MB + 32'h10, 32'h45);
    tx_rdy = 1'b1;
    repeat (6) cyc();
    tx_rdy = 1'b0;
    check("tx_drained", {31'h0, tx_vld}, 32'h0);
    bus_write(MB + 32'h10, 4'h1, 32'h4);
    bus_read("txs_ovf_clr", MB + 32'h10, 32'h02);

    // Push into a full FIFO while the head pops.
    for (int b = 8'h61; b <= 8'h64; b++) begin
      bus_write(MB + 32'hC, 4'h1, 32'(b));
      tx_exp_q.push_back(8'(b));
    end
    tx_rdy = 1'b1;
    bus_write(MB + 32'hC, 4'h1, 32'h5A);
    tx_exp_q.push_back(8'h5A);
    tx_rdy = 1'b0;
    bus_read("txs_push_pop_full", MB + 32'h10, 32'h41);
    tx_rdy = 1'b1;
    repeat (6) cyc();
    tx_rdy = 1'b0;
    check("tx_drained2", {31'h0, tx_vld}, 32'h0);

    // tohost / done / miss.
    bus_write(MB, 4'hF, 32'h0);
    check("done_zero_write", {31'h0, done}, 32'h0);
    bus_write(MB, 4'hF, 32'h1);
    check("done_set", {31'h0, done}, 32'h1);
    check("tohost_val", tohost, 32'h1);
    bus_read("tohost_rd", MB, 32'h1);
    bus_read("rsvd_rd", MB + 32'h14, 32'h0);
    check("rsvd_no_err", {31'h0, bus_err}, 32'h0);
    bus_read("miss_rd", 32'h2000_0000, 32'h0);
    check("miss_bus_err", {31'h0, bus_err}, 32'h1);

    // Mid-operation reset with a byte sitting in the FIFO.
    bus_write(MB + 32'hC, 4'h1, 32'h77);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_done", {31'h0, done}, 32'h0);
    check("rst2_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst2_tohost", tohost, 32'h0);
    check("rst2_tx_vld", {31'h0, tx_vld}, 32'h0);
    bus_read("rst2_mtime_lo", MB + 32'h4, 32'h0);
    bus_read("rst2_status", MB + 32'h10, 32'h02);

    begin
      int n;
      n = 0;
      while ((rd_exp_q.size() != 0 || tx_exp_q.size() != 0) && n < 20) begin
        cyc();
        n++;
      end
    end
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'h0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
